// File: rtl/sbit_link_monitor_pkg.sv
// Shared definitions for the s-bit link monitor: link-state encoding and a
// saturating increment helper used by all counters.
package sbit_link_monitor_pkg;

    typedef enum logic [1:0] {
        LINK_UNLOCKED = 2'd0,
        LINK_LOCKING  = 2'd1,
        LINK_LOCKED   = 2'd2,
        LINK_DEGRADED = 2'd3
    } link_state_t;

    // Increment value unless it has reached max_value; callers cast to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sbit_stuck_detector.sv
// Hot-pin detector for one trigger pin group: flags a non-zero group value
// that has repeated for STUCK_CYCLES consecutive cycles.
module sbit_stuck_detector
    import sbit_link_monitor_pkg::*;
#(
    parameter int unsigned GROUP_W      = 8,
    parameter int unsigned STUCK_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [GROUP_W-1:0] group,
    output logic               stuck
);

    localparam int unsigned CW = $clog2(STUCK_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STUCK_CYCLES);

    logic [GROUP_W-1:0] prev;
    logic [CW-1:0]      cnt;
    logic               rep_c;

    assign rep_c = (group != '0) && (group == prev);

    // Flag is taken from the pre-increment count so it drops on the cycle the pattern breaks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= '0;
            cnt   <= '0;
            stuck <= 1'b0;
        end else begin
            prev <= group;
            if (rep_c) begin
                cnt   <= CW'(sat_inc(32'(cnt), 32'(CNT_MAX)));
                stuck <= (cnt == CNT_MAX);
            end else begin
                cnt   <= '0;
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sbit_link_monitor.sv
// Per-VFAT trigger-link monitor: link-lock FSM, hot-pin suppression,
// s-bit gating and saturating error/hit counters.
module sbit_link_monitor
    import sbit_link_monitor_pkg::*;
#(
    parameter int unsigned MXSBITS      = 64,
    parameter int unsigned MXIO         = 8,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned LOCK_CYCLES  = 256,
    parameter int unsigned STUCK_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [MXSBITS-1:0]   sbits_i,
    input  logic                 aligned_i,
    input  logic                 alignment_error_i,
    input  logic                 mask_i,
    input  logic                 cnt_reset_i,
    output logic [MXSBITS-1:0]   sbits_o,
    output logic                 active_o,
    output logic [1:0]           link_state_o,
    output logic                 link_good_o,
    output logic [MXIO-1:0]      stuck_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [CNT_WIDTH-1:0] hit_cnt_o
);

    localparam int unsigned GROUP_W = MXSBITS / MXIO;
    localparam int unsigned LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0]    LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    link_state_t        state;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [MXSBITS-1:0] stuck_mask_c;
    logic [MXSBITS-1:0] sbits_c;
    logic               pass_c;

    assign link_state_o = state;

    for (genvar g = 0; g < MXIO; g++) begin : g_stuck
        sbit_stuck_detector #(
            .GROUP_W      (GROUP_W),
            .STUCK_CYCLES (STUCK_CYCLES)
        ) u_det (
            .clock   (clock),
            .reset_n (reset_n),
            .group   (sbits_i[g*GROUP_W +: GROUP_W]),
            .stuck   (stuck_o[g])
        );
    end

    // Link-lock state machine; a loss of alignment always wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LINK_UNLOCKED;
            lock_cnt    <= '0;
            link_good_o <= 1'b0;
        end else begin
            link_good_o <= 1'b0;
            case (state)
                LINK_UNLOCKED: begin
                    if (aligned_i && !alignment_error_i) begin
                        state    <= LINK_LOCKING;
                        lock_cnt <= '0;
                    end
                end
                LINK_LOCKING, LINK_DEGRADED: begin
                    if (!aligned_i || alignment_error_i) begin
                        state <= LINK_UNLOCKED;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state       <= LINK_LOCKED;
                        link_good_o <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                LINK_LOCKED: begin
                    if (!aligned_i) begin
                        state <= LINK_UNLOCKED;
                    end else if (alignment_error_i) begin
                        state    <= LINK_DEGRADED;
                        lock_cnt <= '0;
                    end else begin
                        link_good_o <= 1'b1;
                    end
                end
                default: state <= LINK_UNLOCKED;
            endcase
        end
    end

    // Gate on the pre-transition state and the currently registered stuck flags.
    always_comb begin
        stuck_mask_c = '0;
        for (int unsigned g = 0; g < MXIO; g++) begin
            stuck_mask_c[g*GROUP_W +: GROUP_W] = {GROUP_W{stuck_o[g]}};
        end
        pass_c  = !mask_i && ((state == LINK_LOCKED) || (state == LINK_DEGRADED));
        sbits_c = pass_c ? (sbits_i & ~stuck_mask_c) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbits_o  <= '0;
            active_o <= 1'b0;
        end else begin
            sbits_o  <= sbits_c;
            active_o <= |sbits_c;
        end
    end

    // Slow-control counters; a clear overrides a coincident increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_o <= '0;
            hit_cnt_o <= '0;
        end else if (cnt_reset_i) begin
            err_cnt_o <= '0;
            hit_cnt_o <= '0;
        end else begin
            if (alignment_error_i) begin
                err_cnt_o <= CNT_WIDTH'(sat_inc(32'(err_cnt_o), 32'(CNT_MAX)));
            end
            if (|sbits_c) begin
                hit_cnt_o <= CNT_WIDTH'(sat_inc(32'(hit_cnt_o), 32'(CNT_MAX)));
            end
        end
    end

endmodule

// File: tb/tb_sbit_link_monitor.sv
// Scoreboard bench for sbit_link_monitor: a cycle model predicts every
// registered output, expectations are queued at drive time and popped after the edge.
module tb_sbit_link_monitor;

    localparam int LOCK    = 256;
    localparam int STUCK   = 1024;
    localparam int CNT_SAT = 65535;

    logic        clock;
    logic        reset_n;
    logic [63:0] sbits_i;
    logic        aligned;
    logic        err_in;
    logic        mask;
    logic        crst;
    logic [63:0] sbits_o;
    logic        active_o;
    logic [1:0]  link_state_o;
    logic        link_good_o;
    logic [7:0]  stuck_o;
    logic [15:0] err_cnt_o;
    logic [15:0] hit_cnt_o;

    sbit_link_monitor dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .sbits_i           (sbits_i),
        .aligned_i         (aligned),
        .alignment_error_i (err_in),
        .mask_i            (mask),
        .cnt_reset_i       (crst),
        .sbits_o           (sbits_o),
        .active_o          (active_o),
        .link_state_o      (link_state_o),
        .link_good_o       (link_good_o),
        .stuck_o           (stuck_o),
        .err_cnt_o         (err_cnt_o),
        .hit_cnt_o         (hit_cnt_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] sbits;
        logic        active;
        logic [1:0]  state;
        logic        good;
        logic [7:0]  stuck;
        logic [15:0] err;
        logic [15:0] hit;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int       m_state;
    int       m_clean;
    bit [7:0] m_prev [8];
    int       m_run  [8];
    bit [7:0] m_stuck;
    int       m_err;
    int       m_hit;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_clean = 0;
        m_stuck = '0;
        m_err   = 0;
        m_hit   = 0;
        for (int g = 0; g < 8; g++) begin
            m_prev[g] = '0;
            m_run[g]  = 0;
        end
        sb_q.delete();
    endtask

    // Advance the model by one clock edge with the currently driven inputs.
    task automatic model_step(output exp_t e);
        bit [63:0] out;
        bit [7:0]  grp;
        out = '0;
        if (!mask && (m_state == 2 || m_state == 3)) begin
            for (int g = 0; g < 8; g++)
                if (!m_stuck[g]) out[g*8 +: 8] = sbits_i[g*8 +: 8];
        end
        for (int g = 0; g < 8; g++) begin
            grp = sbits_i[g*8 +: 8];
            if (grp != 0 && grp == m_prev[g]) m_run[g]++;
            else m_run[g] = 0;
            m_prev[g]  = grp;
            m_stuck[g] = (m_run[g] > STUCK);
        end
        case (m_state)
            0: if (aligned && !err_in) begin m_state = 1; m_clean = 0; end
            2: if (!aligned) m_state = 0;
               else if (err_in) begin m_state = 3; m_clean = 0; end
            default: begin
                if (!aligned || err_in) m_state = 0;
                else begin
                    m_clean++;
                    if (m_clean == LOCK) m_state = 2;
                end
            end
        endcase
        if (crst) begin
            m_err = 0;
            m_hit = 0;
        end else begin
            if (err_in && m_err < CNT_SAT) m_err++;
            if (out != 0 && m_hit < CNT_SAT) m_hit++;
        end
        e.sbits  = out;
        e.active = (out != 0);
        e.state  = 2'(m_state);
        e.good   = (m_state == 2);
        e.stuck  = m_stuck;
        e.err    = 16'(m_err);
        e.hit    = 16'(m_hit);
    endtask

    // Drive one cycle (called #1 after a rising edge), then compare after the next edge.
    task automatic cycle(input logic [63:0] s);
        exp_t e;
        sbits_i = s;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check_eq("sbits_o",  sbits_o,              e.sbits);
        check_eq("active_o", 64'(active_o),        64'(e.active));
        check_eq("state",    64'(link_state_o),    64'(e.state));
        check_eq("good",     64'(link_good_o),     64'(e.good));
        check_eq("stuck_o",  64'(stuck_o),         64'(e.stuck));
        check_eq("err_cnt",  64'(err_cnt_o),       64'(e.err));
        check_eq("hit_cnt",  64'(hit_cnt_o),       64'(e.hit));
    endtask

    // mode 0: constant, 1: random, 2: alternate pat / pat^0x55.., other: random with keep bits from pat
    task automatic run(input int n, input int mode, input logic [63:0] pat, input logic [63:0] keep);
        logic [63:0] s;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       s = pat;
                1:       s = {$urandom, $urandom};
                2:       s = (i % 2 == 1) ? (pat ^ 64'h5555_5555_5555_5555) : pat;
                default: s = ({$urandom, $urandom} & ~keep) | (pat & keep);
            endcase
            cycle(s);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_sbits"}, sbits_o, 64'd0);
        check_eq({tag, "_misc"},  64'({active_o, link_state_o, link_good_o, stuck_o}), 64'd0);
        check_eq({tag, "_cnts"},  64'({err_cnt_o, hit_cnt_o}), 64'd0);
    endtask

    task automatic relock();
        aligned = 1'b1;
        err_in  = 1'b0;
        run(LOCK + 1, 1, '0, '0);
        check_eq("relock_state", 64'(link_state_o), 64'd2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] G2_MASK = 64'h0000_0000_00FF_0000;

    initial begin
        int hold_err;
        int hold_hit;
        reset_n = 1'b0;
        sbits_i = '0;
        aligned = 1'b0;
        err_in  = 1'b0;
        mask    = 1'b0;
        crst    = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Clean lock from reset
        aligned = 1'b1;
        run(1, 1, '0, '0);
        check_eq("locking_entry", 64'(link_state_o), 64'd1);
        run(LOCK - 1, 1, '0, '0);
        check_eq("still_locking", 64'(link_state_o), 64'd1);
        run(1, 1, '0, '0);
        check_eq("locked_state", 64'(link_state_o), 64'd2);
        check_eq("locked_good",  64'(link_good_o),  64'd1);
        run(20, 1, '0, '0);

        // Single error, recovery, then double error
        err_in = 1'b1;
        run(1, 1, '0, '0);
        check_eq("degraded_state", 64'(link_state_o), 64'd3);
        check_eq("err_cnt_one",    64'(err_cnt_o),    64'd1);
        err_in = 1'b0;
        run(LOCK - 1, 1, '0, '0);
        check_eq("degraded_hold", 64'(link_state_o), 64'd3);
        run(1, 1, '0, '0);
        check_eq("recovered", 64'(link_state_o), 64'd2);
        err_in = 1'b1;
        run(2, 1, '0, '0);
        check_eq("second_err_unlock", 64'(link_state_o), 64'd0);
        err_in = 1'b0;
        aligned = 1'b0;
        run(1, 1, '0, '0);
        check_eq("unlocked_gated", sbits_o, 64'd0);
        check_eq("err_cnt_three", 64'(err_cnt_o), 64'd3);

        // Hot pin on group 2
        relock();
        run(1, 3, 64'h0000_0000_005A_0000, G2_MASK);
        run(STUCK, 3, 64'h0000_0000_005A_0000, G2_MASK);
        check_eq("stuck_not_yet", 64'(stuck_o[2]), 64'd0);
        run(1, 3, 64'h0000_0000_005A_0000, G2_MASK);
        check_eq("stuck_rise", 64'(stuck_o[2]), 64'd1);
        run(1, 3, 64'h0000_0000_005A_0000, G2_MASK);
        check_eq("stuck_gated", 64'(sbits_o[23:16]), 64'd0);
        run(73, 3, 64'h0000_0000_005A_0000, G2_MASK);
        check_eq("stuck_gated_hold", 64'(sbits_o[23:16]), 64'd0);
        run(1, 3, 64'd0, G2_MASK);
        check_eq("stuck_fall", 64'(stuck_o[2]), 64'd0);

        // Masked VFAT with errors
        hold_err = m_err;
        hold_hit = m_hit;
        mask = 1'b1;
        run(10, 1, '0, '0);
        err_in = 1'b1;
        run(5, 1, '0, '0);
        check_eq("mask_hit_frozen", 64'(hit_cnt_o), 64'(hold_hit));
        check_eq("mask_err_counts", 64'(err_cnt_o), 64'(hold_err + 5));
        check_eq("mask_sbits", sbits_o, 64'd0);
        mask   = 1'b0;
        err_in = 1'b0;

        // Hit counter saturation and clear override
        relock();
        run(70000, 2, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        check_eq("hit_saturated", 64'(hit_cnt_o), 64'hFFFF);
        crst = 1'b1;
        run(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        check_eq("cnt_reset_hit", 64'(hit_cnt_o), 64'd0);
        check_eq("cnt_reset_err", 64'(err_cnt_o), 64'd0);
        crst = 1'b0;

        // Alignment loss from LOCKED, LOCKING and DEGRADED
        aligned = 1'b0;
        run(1, 1, '0, '0);
        check_eq("drop_locked", 64'(link_state_o), 64'd0);
        aligned = 1'b1;
        run(10, 1, '0, '0);
        aligned = 1'b0;
        run(1, 1, '0, '0);
        check_eq("drop_locking", 64'(link_state_o), 64'd0);
        relock();
        err_in = 1'b1;
        run(1, 1, '0, '0);
        err_in  = 1'b0;
        aligned = 1'b0;
        run(1, 1, '0, '0);
        check_eq("drop_degraded", 64'(link_state_o), 64'd0);

        // Asynchronous reset mid-operation
        relock();
        run(20, 1, '0, '0);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        run(3, 1, '0, '0);
        check_eq("post_reset_state", 64'(link_state_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
